// File: rtl/bc_disp_pkg.sv
// bc_disp_pkg: symbol codes and digit type shared by the display scanner
package bc_disp_pkg;
    localparam logic [4:0] SYM_P     = 5'd16;
    localparam logic [4:0] SYM_S     = 5'd17;
    localparam logic [4:0] SYM_G     = 5'd18;
    localparam logic [4:0] SYM_B     = 5'd19;
    localparam logic [4:0] SYM_C     = 5'd20;
    localparam logic [4:0] SYM_E     = 5'd21;
    localparam logic [4:0] SYM_DASH  = 5'd22;
    localparam logic [4:0] SYM_BLANK = 5'd31;
    localparam int EN_BIT = 5;
    typedef logic [5:0] digit_t;
endpackage

// File: rtl/bc_seg_decoder.sv
// bc_seg_decoder: 5-bit symbol code to active-low segments a..g (bit 6 = a)
module bc_seg_decoder
    import bc_disp_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);
    always_comb begin
        case (code)
            5'd0:     seg = 7'b0000001;
            5'd1:     seg = 7'b1001111;
            5'd2:     seg = 7'b0010010;
            5'd3:     seg = 7'b0000110;
            5'd4:     seg = 7'b1001100;
            5'd5:     seg = 7'b0100100;
            5'd6:     seg = 7'b0100000;
            5'd7:     seg = 7'b0001111;
            5'd8:     seg = 7'b0000000;
            5'd9:     seg = 7'b0000100;
            5'd10:    seg = 7'b0001000;
            5'd11:    seg = 7'b1100000;
            5'd12:    seg = 7'b0110001;
            5'd13:    seg = 7'b1000010;
            5'd14:    seg = 7'b0110000;
            5'd15:    seg = 7'b0111000;
            SYM_P:    seg = 7'b0011000;
            SYM_S:    seg = 7'b0100100;
            SYM_G:    seg = 7'b0100001;
            SYM_B:    seg = 7'b1100000;
            SYM_C:    seg = 7'b1110010;
            SYM_E:    seg = 7'b0110000;
            SYM_DASH: seg = 7'b1111110;
            default:  seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/bc_display_scan.sv
// bc_display_scan: 8-digit multiplexed common-anode 7-seg scanner
// Define BC_DISPLAY_BLINK_EN to enable whole-display blinking via the blink input.
module bc_display_scan
    import bc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    input  logic       blink,
    output logic [7:0] an,
    output logic [7:0] dec_ddp
);
    localparam int RW = $clog2(REFRESH_DIV);
    logic [RW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    an_q, an_d, dec_ddp_q, dec_ddp_d;
    logic          phase_on;
    logic          wrap;
    logic [6:0]    seg;
    digit_t        digits [8];
    digit_t        sel;
    assign digits = '{d1, d2, d3, d4, d5, d6, d7, d8};
    assign sel    = digits[idx_q];
    assign wrap   = cnt_q == RW'(REFRESH_DIV - 1);
    bc_seg_decoder u_dec (
        .code(sel[4:0]),
        .seg (seg)
    );
`ifdef BC_DISPLAY_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic          bwrap;
    assign bwrap = bcnt_q == BW'(BLINK_DIV - 1);
    always_comb begin
        bcnt_d  = blink ? (bwrap ? '0 : bcnt_q + 1'b1) : '0;
        phase_d = blink ? phase_q ^ bwrap : 1'b1;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
    // next phase gates the anodes so blink=0 releases the display on the very next edge
    assign phase_on = phase_d;
`else
    logic unused_blink;
    assign unused_blink = blink;
    assign phase_on     = 1'b1;
`endif
    always_comb begin
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        idx_d     = wrap ? idx_q + 1'b1 : idx_q;
        an_d      = (sel[EN_BIT] && phase_on) ? ~(8'h80 >> idx_q) : 8'hFF;
        dec_ddp_d = sel[EN_BIT] ? {seg, 1'b1} : 8'hFF;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            an_q      <= 8'hFF;
            dec_ddp_q <= 8'hFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            dec_ddp_q <= dec_ddp_d;
        end
    end
    assign an      = an_q;
    assign dec_ddp = dec_ddp_q;
endmodule
